sseg_scan_controller: RTL and testbench

- Time-multiplexed scan controller for the 8-digit common-anode seven-segment display.
- Cycles the active digit and drives the active-low anode strobes AN, the segments and DP from a double-buffered 32-bit hex frame.
- Inserts a blanking gap between digits to suppress ghosting.
- Sits between the application logic (which loads display values) and the board display pins.

---
 rtl/sseg_scan_controller.sv | 253 +++++++++++++++++++++++++
 tb/tb_sseg_scan_controller.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sseg_scan_controller.sv
`default_nettype none
// ============================================================================
// Module   : sseg_scan_controller
// Brief    : Time-multiplexed scan controller for an 8-digit common-anode
//            seven-segment display. Scans digits 0..7, each lit for TICK_DIV
//            cycles and followed by BLANK_CYCLES of all-anodes-off. The frame
//            is double-buffered: loads land in a pending buffer and are
//            committed at frame end, or at once while idle.
// Options  : SSEG_LEADING_ZERO_BLANK_EN - blank leading zero digits
// Revision : 1.0 - initial release
// ============================================================================
module sseg_scan_controller #(
    parameter int TICK_DIV     = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        en,
    input  logic        load,
    input  logic [31:0] data_in,
    input  logic [7:0]  dp_in,
    input  logic [7:0]  digit_mask,
    output logic        pending,
    output logic        frame_done,
    output logic [7:0]  AN,
    output logic [6:0]  seg,
    output logic        DP
);

    // One counter serves both SHOW and BLANK slots, so it is sized for the
    // longer of the two.
    localparam int C_CNT_MAX = (TICK_DIV > BLANK_CYCLES) ? TICK_DIV : BLANK_CYCLES;
    localparam int C_CNT_W   = (C_CNT_MAX > 1) ? $clog2(C_CNT_MAX) : 1;

    localparam logic [C_CNT_W-1:0] C_SHOW_LAST  = C_CNT_W'(TICK_DIV - 1);
    localparam logic [C_CNT_W-1:0] C_BLANK_LAST = C_CNT_W'(BLANK_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHOW  = 2'd1,
        ST_BLANK = 2'd2
    } state_t;

    // Scan state
    state_t             r_state;
    state_t             w_state_nxt;
    logic [C_CNT_W-1:0] r_cnt;
    logic [C_CNT_W-1:0] w_cnt_nxt;
    logic [2:0]         r_idx;
    logic [2:0]         w_idx_nxt;
    logic               w_frame_end;

    // Frame buffers
    logic [31:0]        r_act_data;
    logic [7:0]         r_act_dp;
    logic [7:0]         r_act_mask;
    logic [31:0]        r_pnd_data;
    logic [7:0]         r_pnd_dp;
    logic [7:0]         r_pnd_mask;
    logic               r_pending;
    logic               w_commit;

    // Display path
    logic [3:0]         w_nib;
    logic [6:0]         w_seg_dec;
    logic [7:0]         w_lz_vec;
    logic [7:0]         w_an;
    logic [6:0]         w_seg;
    logic               w_dp;
    logic [7:0]         r_an;
    logic [6:0]         r_seg;
    logic               r_dp;
    logic               r_frame_done;

    // State register: scan state, slot counter and digit index
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Next-state logic: IDLE -> SHOW -> BLANK -> SHOW ... ; en low aborts to IDLE
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_frame_end = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (en) begin
                    w_state_nxt = ST_SHOW;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                end
            end
            ST_SHOW: begin
                if (!en) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                end else if (r_cnt == C_SHOW_LAST) begin
                    w_state_nxt = ST_BLANK;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + 1'b1;
                end
            end
            ST_BLANK: begin
                if (!en) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                end else if (r_cnt == C_BLANK_LAST) begin
                    // The 3-bit index wraps 7 -> 0 on its own
                    w_state_nxt = ST_SHOW;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = r_idx + 3'd1;
                    w_frame_end = (r_idx == 3'd7);
                end else begin
                    w_cnt_nxt   = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
                w_idx_nxt   = '0;
            end
        endcase
    end

    // A waiting frame goes live while idle, or on the edge that closes digit 7
    assign w_commit = r_pending && ((r_state == ST_IDLE) || w_frame_end);

    // Frame buffers: a load always lands in pending, so a load coinciding
    // with a commit keeps pending set while the older frame goes live
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_act_data <= '0;
            r_act_dp   <= '0;
            r_act_mask <= '0;
            r_pnd_data <= '0;
            r_pnd_dp   <= '0;
            r_pnd_mask <= '0;
            r_pending  <= 1'b0;
        end else begin
            if (w_commit) begin
                r_act_data <= r_pnd_data;
                r_act_dp   <= r_pnd_dp;
                r_act_mask <= r_pnd_mask;
            end
            if (load) begin
                r_pnd_data <= data_in;
                r_pnd_dp   <= dp_in;
                r_pnd_mask <= digit_mask;
                r_pending  <= 1'b1;
            end else if (w_commit) begin
                r_pending  <= 1'b0;
            end
        end
    end

    assign w_nib = r_act_data[{r_idx, 2'b00} +: 4];

    // Hex nibble to active-low {g,f,e,d,c,b,a}
    always_comb begin
        w_seg_dec = 7'h7F;
        case (w_nib)
            4'h0: w_seg_dec = 7'h40;
            4'h1: w_seg_dec = 7'h79;
            4'h2: w_seg_dec = 7'h24;
            4'h3: w_seg_dec = 7'h30;
            4'h4: w_seg_dec = 7'h19;
            4'h5: w_seg_dec = 7'h12;
            4'h6: w_seg_dec = 7'h02;
            4'h7: w_seg_dec = 7'h78;
            4'h8: w_seg_dec = 7'h00;
            4'h9: w_seg_dec = 7'h10;
            4'hA: w_seg_dec = 7'h08;
            4'hB: w_seg_dec = 7'h03;
            4'hC: w_seg_dec = 7'h46;
            4'hD: w_seg_dec = 7'h21;
            4'hE: w_seg_dec = 7'h06;
            4'hF: w_seg_dec = 7'h0E;
            default: w_seg_dec = 7'h7F;
        endcase
    end

`ifdef SSEG_LEADING_ZERO_BLANK_EN
    logic w_above_zero;

    // Walk from digit 7 down: a digit is a leading zero when it is zero and
    // every enabled digit above it is zero too; digit 0 always shows
    always_comb begin
        w_lz_vec     = 8'h00;
        w_above_zero = 1'b1;
        for (int i = 7; i >= 1; i--) begin
            if ((r_act_data[4*i +: 4] == 4'h0) && w_above_zero) begin
                w_lz_vec[i] = 1'b1;
            end
            if (r_act_mask[i] && (r_act_data[4*i +: 4] != 4'h0)) begin
                w_above_zero = 1'b0;
            end
        end
    end
`else
    assign w_lz_vec = 8'h00;
`endif

    // Pin values for the current digit; en low blanks immediately
    always_comb begin
        w_an  = 8'hFF;
        w_seg = 7'h7F;
        w_dp  = 1'b1;
        if (en && (r_state == ST_SHOW)) begin
            w_seg = w_seg_dec;
            if (r_act_mask[r_idx]) begin
                w_dp = ~r_act_dp[r_idx];
                if (!w_lz_vec[r_idx]) begin
                    w_an = ~(8'h01 << r_idx);
                end
            end
        end
    end

    // Output registers keep the pins glitch-free
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_an         <= 8'hFF;
            r_seg        <= 7'h7F;
            r_dp         <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_an         <= w_an;
            r_seg        <= w_seg;
            r_dp         <= w_dp;
            r_frame_done <= w_frame_end;
        end
    end

    assign AN         = r_an;
    assign seg        = r_seg;
    assign DP         = r_dp;
    assign frame_done = r_frame_done;
    assign pending    = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_sseg_scan_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_sseg_scan_controller
// Brief    : Self-checking bench for sseg_scan_controller with a frame-position
//            reference model (TICK_DIV=4, BLANK_CYCLES=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sseg_scan_controller;

    localparam int TD    = 4;
    localparam int BC    = 2;
    localparam int SLOT  = TD + BC;
    localparam int FRAME = 8 * SLOT;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        en;
    logic        load;
    logic [31:0] data_in;
    logic [7:0]  dp_in;
    logic [7:0]  digit_mask;
    logic        pending;
    logic        frame_done;
    logic [7:0]  AN;
    logic [6:0]  seg;
    logic        DP;

    int checks   = 0;
    int failures = 0;

    sseg_scan_controller #(
        .TICK_DIV     (TD),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .en         (en),
        .load       (load),
        .data_in    (data_in),
        .dp_in      (dp_in),
        .digit_mask (digit_mask),
        .pending    (pending),
        .frame_done (frame_done),
        .AN         (AN),
        .seg        (seg),
        .DP         (DP)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic        m_run;      // scan running (not idle)
    int          m_pos;      // cycle position within the 48-cycle frame
    logic [31:0] m_act_data, m_pnd_data;
    logic [7:0]  m_act_dp, m_pnd_dp, m_act_mask, m_pnd_mask;
    logic        m_pnd;
    logic [7:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic        e_fd;

    function automatic logic [3:0] nib_of(int d);
        return 4'(m_act_data >> (4 * d));
    endfunction

`ifdef SSEG_LEADING_ZERO_BLANK_EN
    function automatic logic upper_zero(int d);
        int v = 0;
        if (d == 0) return 1'b0;
        for (int j = d; j < 8; j++)
            if (j == d || m_act_mask[j]) v += int'(nib_of(j));
        return (v == 0);
    endfunction
`endif

    function automatic logic [7:0] exp_an(int p);
        int d = p / SLOT;
        if ((p % SLOT) >= TD || !m_act_mask[d]) return 8'hFF;
`ifdef SSEG_LEADING_ZERO_BLANK_EN
        if (upper_zero(d)) return 8'hFF;
`endif
        return 8'hFF ^ (8'd1 << d);
    endfunction

    function automatic logic [6:0] exp_seg(int p);
        if ((p % SLOT) >= TD) return 7'h7F;
        return hex_tab[nib_of(p / SLOT)];
    endfunction

    function automatic logic exp_dp(int p);
        int d = p / SLOT;
        if ((p % SLOT) >= TD || !m_act_mask[d]) return 1'b1;
        return ~m_act_dp[d];
    endfunction

    wire m_commit = m_pnd && (!m_run || (en && m_pos == FRAME - 1));

    always @(posedge clk) begin
        if (!reset_n) begin
            m_run <= 1'b0; m_pos <= 0; m_pnd <= 1'b0;
            m_act_data <= '0; m_act_dp <= '0; m_act_mask <= '0;
            m_pnd_data <= '0; m_pnd_dp <= '0; m_pnd_mask <= '0;
            e_an <= 8'hFF; e_seg <= 7'h7F; e_dp <= 1'b1; e_fd <= 1'b0;
        end else begin
            if (en && m_run) begin
                e_an <= exp_an(m_pos); e_seg <= exp_seg(m_pos); e_dp <= exp_dp(m_pos);
            end else begin
                e_an <= 8'hFF; e_seg <= 7'h7F; e_dp <= 1'b1;
            end
            e_fd <= en && m_run && (m_pos == FRAME - 1);
            if (m_commit) begin
                m_act_data <= m_pnd_data; m_act_dp <= m_pnd_dp; m_act_mask <= m_pnd_mask;
            end
            if (load) begin
                m_pnd_data <= data_in; m_pnd_dp <= dp_in; m_pnd_mask <= digit_mask; m_pnd <= 1'b1;
            end else if (m_commit) begin
                m_pnd <= 1'b0;
            end
            m_run <= en;
            m_pos <= (en && m_run) ? (m_pos + 1) % FRAME : 0;
        end
    end

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0; en = 1'b1; load = 1'b1;
        data_in = $urandom; dp_in = 8'($urandom); digit_mask = 8'hFF;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (AN !== 8'hFF || seg !== 7'h7F || DP !== 1'b1 || pending !== 1'b0 || frame_done !== 1'b0) begin
                failures++;
                $display("FAIL reset: got AN=%h seg=%h DP=%b pending=%b fd=%b, want FF 7F 1 0 0",
                         AN, seg, DP, pending, frame_done);
            end
        end
        reset_n = 1'b1; en = 1'b0; load = 1'b0;
    endtask

    task automatic test_load_idle();
        logic [7:0] want;
        load = 1'b1; data_in = 32'h89ABCDEF; dp_in = 8'h01; digit_mask = 8'hFF;
        @(negedge clk);
        load = 1'b0;
        checks++;
        if (pending !== 1'b1) begin
            failures++; $display("FAIL load_idle_pending_set: got %b want 1", pending);
        end
        @(negedge clk);
        checks++;
        if (pending !== 1'b0) begin
            failures++; $display("FAIL load_idle_commit: got %b want 0", pending);
        end
        en = 1'b1;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            checks++;
            if ({AN, seg, DP, pending, frame_done} !== {e_an, e_seg, e_dp, m_pnd, e_fd}) begin
                failures++;
                $display("FAIL load_idle cyc%0d: got AN=%h seg=%h DP=%b pend=%b fd=%b want %h %h %b %b %b",
                         i, AN, seg, DP, pending, frame_done, e_an, e_seg, e_dp, m_pnd, e_fd);
            end
            if (i <= 10) begin
                want = (i >= 1 && i <= 4) ? 8'hFE : (i >= 7) ? 8'hFD : 8'hFF;
                checks++;
                if (AN !== want) begin
                    failures++; $display("FAIL first_show cyc%0d: AN got %h want %h", i, AN, want);
                end
            end
            if (AN === 8'hFE) begin
                checks++;
                if (seg !== 7'h0E || DP !== 1'b0) begin
                    failures++; $display("FAIL digit0: got seg=%h DP=%b want 0E 0", seg, DP);
                end
            end
            if (AN === 8'h7F) begin
                checks++;
                if (seg !== 7'h00 || DP !== 1'b1) begin
                    failures++; $display("FAIL digit7: got seg=%h DP=%b want 00 1", seg, DP);
                end
            end
        end
    endtask

    task automatic test_scan_timing();
        int last_fd = -1;
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(negedge clk);
            checks++;
            if ({AN, seg, DP, pending, frame_done} !== {e_an, e_seg, e_dp, m_pnd, e_fd}) begin
                failures++;
                $display("FAIL scan cyc%0d: got AN=%h seg=%h DP=%b pend=%b fd=%b want %h %h %b %b %b",
                         i, AN, seg, DP, pending, frame_done, e_an, e_seg, e_dp, m_pnd, e_fd);
            end
            if (frame_done === 1'b1) begin
                if (last_fd >= 0) begin
                    checks++;
                    if (i - last_fd != FRAME) begin
                        failures++; $display("FAIL frame_period: got %0d want %0d", i - last_fd, FRAME);
                    end
                end
                last_fd = i;
            end
        end
    endtask

    task automatic test_latest_wins();
        bit l1 = 0, l2 = 0, fd_seen = 0, saw_two = 0;
        for (int i = 0; i < 4 * FRAME; i++) begin
            load = 1'b0;
            if (!l1 && m_run && m_pos / SLOT == 3) begin
                load = 1'b1; data_in = 32'h00000001; dp_in = 8'h00; digit_mask = 8'hFF; l1 = 1;
            end else if (l1 && !l2 && m_pos / SLOT == 5) begin
                load = 1'b1; data_in = 32'h00000002; l2 = 1;
            end
            @(negedge clk);
            checks++;
            if ({AN, seg, DP, pending, frame_done} !== {e_an, e_seg, e_dp, m_pnd, e_fd}) begin
                failures++;
                $display("FAIL latest cyc%0d: got AN=%h seg=%h DP=%b pend=%b fd=%b want %h %h %b %b %b",
                         i, AN, seg, DP, pending, frame_done, e_an, e_seg, e_dp, m_pnd, e_fd);
            end
            if (l1 && !fd_seen) begin
                if (frame_done === 1'b1) begin
                    fd_seen = 1;
                    checks++;
                    if (pending !== 1'b0) begin
                        failures++; $display("FAIL latest_commit: pending got %b want 0", pending);
                    end
                end else begin
                    checks++;
                    if (pending !== 1'b1) begin
                        failures++; $display("FAIL latest_hold: pending got %b want 1", pending);
                    end
                end
            end
            if (AN === 8'hFE) begin
                checks++;
                if (seg === 7'h79) begin
                    failures++; $display("FAIL latest_stale: value 1 displayed, seg=%h", seg);
                end
                if (seg === 7'h24) saw_two = 1;
            end
        end
        load = 1'b0;
        checks++;
        if (saw_two !== 1'b1) begin
            failures++; $display("FAIL latest_shown: value 2 seen=%b want 1", saw_two);
        end
    endtask

    task automatic test_mask();
        int last_fd = -1;
        load = 1'b1; data_in = $urandom; dp_in = 8'($urandom); digit_mask = 8'h0F;
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(negedge clk);
            load = 1'b0;
            checks++;
            if ({AN, seg, DP, pending, frame_done} !== {e_an, e_seg, e_dp, m_pnd, e_fd}) begin
                failures++;
                $display("FAIL mask cyc%0d: got AN=%h seg=%h DP=%b pend=%b fd=%b want %h %h %b %b %b",
                         i, AN, seg, DP, pending, frame_done, e_an, e_seg, e_dp, m_pnd, e_fd);
            end
            if (i > FRAME + 2) begin
                checks++;
                if (AN === 8'hBF || AN === 8'hDF || AN === 8'hEF || AN === 8'h7F) begin
                    failures++; $display("FAIL mask_an: got AN=%h for a masked digit", AN);
                end
            end
            if (frame_done === 1'b1) begin
                if (last_fd >= 0) begin
                    checks++;
                    if (i - last_fd != FRAME) begin
                        failures++; $display("FAIL mask_period: got %0d want %0d", i - last_fd, FRAME);
                    end
                end
                last_fd = i;
            end
        end
    endtask

    task automatic test_en_drop();
        bit found = 0;
        load = 1'b1; data_in = $urandom | 32'h1000_0000; dp_in = 8'($urandom); digit_mask = 8'hFF;
        @(negedge clk);
        load = 1'b0;
        for (int i = 0; i < 3 * FRAME && !found; i++) begin
            @(negedge clk);
            checks++;
            if ({AN, seg, DP, pending, frame_done} !== {e_an, e_seg, e_dp, m_pnd, e_fd}) begin
                failures++;
                $display("FAIL en_drop_wait cyc%0d: got AN=%h seg=%h want %h %h", i, AN, seg, e_an, e_seg);
            end
            if (!m_pnd && m_run && m_pos == 5 * SLOT + 1) found = 1;
        end
        checks++;
        if (!found) begin
            failures++; $display("FAIL en_drop_timeout: digit 5 not reached, found=%b want 1", found);
        end
        checks++;
        if (AN !== 8'hDF) begin
            failures++; $display("FAIL en_drop_lit: got AN=%h want DF", AN);
        end
        en = 1'b0;
        @(negedge clk);
        checks++;
        if (AN !== 8'hFF || seg !== 7'h7F || DP !== 1'b1) begin
            failures++; $display("FAIL en_drop_blank: got AN=%h seg=%h DP=%b want FF 7F 1", AN, seg, DP);
        end
        repeat (3) @(negedge clk);
        en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if ({AN, seg, DP, pending, frame_done} !== {e_an, e_seg, e_dp, m_pnd, e_fd}) begin
                failures++;
                $display("FAIL en_restart_model cyc%0d: got AN=%h seg=%h want %h %h", i, AN, seg, e_an, e_seg);
            end
        end
        checks++;
        if (AN !== 8'hFE) begin
            failures++; $display("FAIL en_restart: got AN=%h want FE", AN);
        end
    endtask

    task automatic test_lzb();
        bit fd_seen = 0;
        load = 1'b1; data_in = 32'h00000120; dp_in = 8'h00; digit_mask = 8'hFF;
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(negedge clk);
            load = 1'b0;
            checks++;
            if ({AN, seg, DP, pending, frame_done} !== {e_an, e_seg, e_dp, m_pnd, e_fd}) begin
                failures++;
                $display("FAIL lzb cyc%0d: got AN=%h seg=%h DP=%b pend=%b fd=%b want %h %h %b %b %b",
                         i, AN, seg, DP, pending, frame_done, e_an, e_seg, e_dp, m_pnd, e_fd);
            end
            if (frame_done === 1'b1) fd_seen = 1;
            if (fd_seen) begin
                if (AN === 8'hFE || AN === 8'hFD || AN === 8'hFB) begin
                    checks++;
                    if (seg !== ((AN === 8'hFE) ? 7'h40 : (AN === 8'hFD) ? 7'h24 : 7'h79)) begin
                        failures++; $display("FAIL lzb_low: AN=%h got seg=%h", AN, seg);
                    end
                end
`ifdef SSEG_LEADING_ZERO_BLANK_EN
                checks++;
                if (AN === 8'hF7 || AN === 8'hEF || AN === 8'hDF || AN === 8'hBF || AN === 8'h7F) begin
                    failures++; $display("FAIL lzb_blank: got AN=%h want FF for leading zero", AN);
                end
`else
                if (AN === 8'hF7) begin
                    checks++;
                    if (seg !== 7'h40) begin
                        failures++; $display("FAIL lzb_zero_shown: got seg=%h want 40", seg);
                    end
                end
`endif
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            reset_n    = ($urandom % 200) != 0;
            en         = ($urandom % 16) != 0;
            load       = ($urandom % 8) == 0;
            data_in    = $urandom;
            dp_in      = 8'($urandom);
            digit_mask = 8'($urandom);
            @(negedge clk);
            checks++;
            if ({AN, seg, DP, pending, frame_done} !== {e_an, e_seg, e_dp, m_pnd, e_fd}) begin
                failures++;
                $display("FAIL random cyc%0d: got AN=%h seg=%h DP=%b pend=%b fd=%b want %h %h %b %b %b",
                         i, AN, seg, DP, pending, frame_done, e_an, e_seg, e_dp, m_pnd, e_fd);
            end
        end
        reset_n = 1'b1; en = 1'b1; load = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; en = 1'b0; load = 1'b0;
        data_in = '0; dp_in = '0; digit_mask = '0;
        test_reset();
        test_load_idle();
        test_scan_timing();
        test_latest_wins();
        test_mask();
        test_en_drop();
        test_lzb();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
